// File: rtl/aligner_pkg.sv
// Shared types and constants for the 66-bit block aligner and its lock controller.
package aligner_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SLIP   = 2'd1,
      SETTLE = 2'd2,
      LOCKED = 2'd3
   } lock_state_t;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   localparam int unsigned OFFSET_W = 7;

endpackage

// File: rtl/hdr_check.sv
// Combinational sync-header classifier: only the two legal 66b sync patterns are good.
module hdr_check
   import aligner_pkg::*;
(
   input  logic [1:0] hdr_i,
   output logic       good_o
);

   always_comb begin
      good_o = (hdr_i == SYNC_DATA) || (hdr_i == SYNC_CTRL);
   end

endmodule

// File: rtl/block_lock_ctrl.sv
// Block-lock FSM: hunts for sync-header alignment by slipping the aligner offset,
// then monitors header errors per window once locked.
module block_lock_ctrl
   import aligner_pkg::*;
#(
   parameter int unsigned OFFSET_MAX    = 65,
   parameter int unsigned GOOD_TO_LOCK  = 64,
   parameter int unsigned WINDOW        = 64,
   parameter int unsigned BAD_TO_UNLOCK = 16,
   parameter int unsigned SETTLE        = 2
)
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                hdr_dv_i,
   input  logic [1:0]          hdr_i,
   output logic [OFFSET_W-1:0] block_offset_o,
   output logic                slip_o,
   output logic                locked_o,
   output logic [7:0]          slip_cnt_o
);

   localparam int unsigned GOOD_W = $clog2(GOOD_TO_LOCK + 1);
   localparam int unsigned WIN_W  = $clog2(WINDOW + 1);
   localparam int unsigned BAD_W  = $clog2(BAD_TO_UNLOCK + 1);
   localparam int unsigned SET_W  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   lock_state_t          state;
   logic [GOOD_W-1:0]    good_cnt;
   logic [WIN_W-1:0]     win_cnt;
   logic [BAD_W-1:0]     bad_cnt;
   logic [SET_W-1:0]     settle_cnt;

   logic                 hdr_good;
   logic [GOOD_W-1:0]    good_nxt;
   logic [WIN_W-1:0]     win_nxt;
   logic [BAD_W-1:0]     bad_nxt;
   logic [OFFSET_W-1:0]  offset_nxt;
   logic                 enter_slip;

   hdr_check u_hdr_check (
      .hdr_i  (hdr_i),
      .good_o (hdr_good)
   );

   always_comb begin
      good_nxt   = good_cnt + GOOD_W'(1);
      win_nxt    = win_cnt + WIN_W'(1);
      bad_nxt    = bad_cnt;
      if (!hdr_good) begin
         bad_nxt = bad_cnt + BAD_W'(1);
      end
      offset_nxt = (block_offset_o == OFFSET_W'(OFFSET_MAX)) ? '0
                                                             : block_offset_o + OFFSET_W'(1);
      enter_slip = 1'b0;
      if (hdr_dv_i) begin
         if (state == HUNT && !hdr_good) begin
            enter_slip = 1'b1;
         end
         // Unlock is tested before window rollover so a 16th bad on header 64 wins.
         if (state == LOCKED && bad_nxt == BAD_W'(BAD_TO_UNLOCK)) begin
            enter_slip = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= HUNT;
         block_offset_o <= '0;
         slip_o         <= 1'b0;
         locked_o       <= 1'b0;
         slip_cnt_o     <= '0;
         good_cnt       <= '0;
         win_cnt        <= '0;
         bad_cnt        <= '0;
         settle_cnt     <= '0;
      end else begin
         slip_o <= 1'b0;
         // Slip outputs are registered on entry so they are visible during the SLIP cycle.
         if (enter_slip) begin
            state          <= SLIP;
            block_offset_o <= offset_nxt;
            slip_o         <= 1'b1;
            locked_o       <= 1'b0;
            if (slip_cnt_o != '1) begin
               slip_cnt_o <= slip_cnt_o + 8'd1;
            end
            good_cnt   <= '0;
            win_cnt    <= '0;
            bad_cnt    <= '0;
            settle_cnt <= SET_W'(SETTLE);
         end else begin
            case (state)
               HUNT: begin
                  if (hdr_dv_i) begin
                     if (good_nxt == GOOD_W'(GOOD_TO_LOCK)) begin
                        state    <= LOCKED;
                        locked_o <= 1'b1;
                        good_cnt <= '0;
                        win_cnt  <= '0;
                        bad_cnt  <= '0;
                     end else begin
                        good_cnt <= good_nxt;
                     end
                  end
               end
               SLIP: begin
                  good_cnt <= '0;
                  state    <= (SETTLE == 0) ? HUNT : aligner_pkg::SETTLE;
               end
               aligner_pkg::SETTLE: begin
                  if (hdr_dv_i) begin
                     if (settle_cnt <= SET_W'(1)) begin
                        state      <= HUNT;
                        settle_cnt <= '0;
                        good_cnt   <= '0;
                     end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                     end
                  end
               end
               LOCKED: begin
                  if (hdr_dv_i) begin
                     if (win_nxt == WIN_W'(WINDOW)) begin
                        win_cnt <= '0;
                        bad_cnt <= '0;
                     end else begin
                        win_cnt <= win_nxt;
                        bad_cnt <= bad_nxt;
                     end
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_block_lock_ctrl.sv
// Scoreboard bench for block_lock_ctrl: directed header streams with hand-computed lock/slip outcomes.
module tb_block_lock_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       hdr_dv;
   logic [1:0] hdr;
   logic [6:0] off;
   logic       slip;
   logic       locked;
   logic [7:0] slip_cnt;

   always #5 clk = ~clk;

   block_lock_ctrl #(
      .OFFSET_MAX    (65),
      .GOOD_TO_LOCK  (64),
      .WINDOW        (64),
      .BAD_TO_UNLOCK (16),
      .SETTLE        (2)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .hdr_dv_i       (hdr_dv),
      .hdr_i          (hdr),
      .block_offset_o (off),
      .slip_o         (slip),
      .locked_o       (locked),
      .slip_cnt_o     (slip_cnt)
   );

   typedef struct {
      int         when;
      string      name;
      logic [6:0] off;
      logic       sl;
      logic       lk;
      logic [7:0] cnt;
   } chk_t;

   typedef struct {
      logic [6:0] off;
      logic [7:0] cnt;
   } slip_t;

   chk_t  tq[$];
   slip_t sq[$];
   chk_t  cur_c;
   slip_t cur_s;
   int    vectors = 0;
   int    miscompares = 0;
   int    cyc = 0;
   int    exp_off;
   int    exp_cnt;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every slip pulse pops the slip queue; timed status checks pop when due.
   always @(negedge clk) begin
      if (slip === 1'b1) begin
         vectors++;
         if (sq.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_slip: got off=%0d cnt=%0d, want no slip", off, slip_cnt);
         end else begin
            cur_s = sq.pop_front();
            if (off !== cur_s.off || slip_cnt !== cur_s.cnt || locked !== 1'b0) begin
               miscompares++;
               $display("FAIL slip_pulse: got off=%0d cnt=%0d lock=%0b, want off=%0d cnt=%0d lock=0",
                        off, slip_cnt, locked, cur_s.off, cur_s.cnt);
            end
         end
      end
      while (tq.size() > 0 && tq[0].when <= cyc) begin
         cur_c = tq.pop_front();
         vectors++;
         if (off !== cur_c.off || slip !== cur_c.sl || locked !== cur_c.lk || slip_cnt !== cur_c.cnt) begin
            miscompares++;
            $display("FAIL %s: got off=%0d slip=%0b lock=%0b cnt=%0d, want off=%0d slip=%0b lock=%0b cnt=%0d",
                     cur_c.name, off, slip, locked, slip_cnt, cur_c.off, cur_c.sl, cur_c.lk, cur_c.cnt);
         end
      end
   end

   task automatic expect_now(input string n, input logic [6:0] o, input logic s,
                             input logic l, input logic [7:0] c);
      chk_t e;
      e.when = cyc;
      e.name = n;
      e.off  = o;
      e.sl   = s;
      e.lk   = l;
      e.cnt  = c;
      tq.push_back(e);
   endtask

   task automatic strobe(input logic [1:0] h);
      hdr_dv = 1'b1;
      hdr    = h;
      @(posedge clk);
      #1;
      hdr_dv = 1'b0;
      hdr    = 2'b00;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [1:0] good_hdr(input int i);
      return (i % 2 == 0) ? 2'b01 : 2'b10;
   endfunction

   task automatic slip_expected();
      slip_t s;
      exp_off = (exp_off == 65) ? 0 : exp_off + 1;
      if (exp_cnt < 255) exp_cnt++;
      s.off = 7'(exp_off);
      s.cnt = 8'(exp_cnt);
      sq.push_back(s);
   endtask

   // Bad header in HUNT, then two settle strobes whose contents must be ignored.
   task automatic hunt_slip();
      strobe(2'b11);
      slip_expected();
      expect_now("hunt_slip_pulse", 7'(exp_off), 1'b1, 1'b0, 8'(exp_cnt));
      gap(1);
      strobe(2'b00);
      gap(1);
      strobe(2'b11);
      gap(1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      slip_t s;
      rst = 1'b1; hdr_dv = 1'b0; hdr = 2'b00;
      exp_off = 0; exp_cnt = 0;
      @(posedge clk); #1;
      gap(2);
      rst = 1'b0;
      expect_now("reset", 7'd0, 1'b0, 1'b0, 8'd0);
      gap(1);

      // 64 good headers at 8-cycle spacing
      for (int i = 0; i < 64; i++) begin
         strobe(good_hdr(i));
         if (i == 62) expect_now("pre_lock", 7'd0, 1'b0, 1'b0, 8'd0);
         if (i == 63) expect_now("lock_a", 7'd0, 1'b0, 1'b1, 8'd0);
         gap(7);
      end

      // Window 1: 15 bad + 49 good stays locked
      for (int i = 0; i < 15; i++) begin strobe(2'b11); gap(1); end
      for (int i = 0; i < 49; i++) begin strobe(good_hdr(i)); gap(1); end
      expect_now("window_clear", 7'd0, 1'b0, 1'b1, 8'd0);

      // Window 2: 15 bad, 48 good, 16th bad on header 64
      for (int i = 0; i < 15; i++) begin strobe(2'b00); gap(1); end
      for (int i = 0; i < 48; i++) begin strobe(good_hdr(i)); gap(1); end
      expect_now("pre_unlock", 7'd0, 1'b0, 1'b1, 8'd0);
      strobe(2'b00);
      slip_expected();
      expect_now("unlock_64th", 7'd1, 1'b1, 1'b0, 8'd1);
      gap(1);
      strobe(2'b11); gap(1);
      strobe(2'b00); gap(1);
      expect_now("settle_done", 7'd1, 1'b0, 1'b0, 8'd1);

      // 10 good then a bad header in HUNT; two strobes ignored; relock
      for (int i = 0; i < 10; i++) begin strobe(good_hdr(i)); gap(7); end
      strobe(2'b11);
      slip_expected();
      expect_now("hunt_slip", 7'd2, 1'b1, 1'b0, 8'd2);
      gap(7);
      strobe(2'b11); gap(7);
      strobe(2'b00); gap(7);
      for (int i = 0; i < 64; i++) begin
         strobe(good_hdr(i));
         if (i == 62) expect_now("pre_relock", 7'd2, 1'b0, 1'b0, 8'd2);
         if (i == 63) expect_now("relock", 7'd2, 1'b0, 1'b1, 8'd2);
      end
      gap(1);

      // 16 consecutive bad headers while locked
      for (int i = 0; i < 16; i++) begin
         strobe(2'b11);
         if (i == 15) begin
            slip_expected();
            expect_now("lock_loss", 7'd3, 1'b1, 1'b0, 8'd3);
         end
      end
      gap(1);
      strobe(2'b11); gap(1);
      strobe(2'b11); gap(1);

      // Walk offset 3 -> 65, then wrap to 0
      for (int i = 0; i < 62; i++) hunt_slip();
      expect_now("at_max", 7'd65, 1'b0, 1'b0, 8'd65);
      strobe(2'b11);
      exp_off = 0; exp_cnt = 66;
      s.off = 7'd0; s.cnt = 8'd66;
      sq.push_back(s);
      expect_now("wrap", 7'd0, 1'b1, 1'b0, 8'd66);
      gap(1);
      strobe(2'b11); gap(1);
      strobe(2'b11); gap(1);

      // 200 further slips: count saturates, offset 200 mod 66 = 2
      for (int i = 0; i < 200; i++) hunt_slip();
      expect_now("saturated", 7'd2, 1'b0, 1'b0, 8'd255);

      // Reset landing on the SLIP cycle
      strobe(2'b11);
      slip_expected();
      expect_now("slip_before_rst", 7'd3, 1'b1, 1'b0, 8'd255);
      rst = 1'b1;
      gap(1);
      rst = 1'b0;
      exp_off = 0; exp_cnt = 0;
      expect_now("rst_in_slip", 7'd0, 1'b0, 1'b0, 8'd0);

      // Back-to-back strobes counted every cycle
      for (int i = 0; i < 64; i++) begin
         strobe(good_hdr(i));
         if (i == 62) expect_now("b2b_pre_lock", 7'd0, 1'b0, 1'b0, 8'd0);
         if (i == 63) expect_now("b2b_lock", 7'd0, 1'b0, 1'b1, 8'd0);
      end
      gap(3);

      vectors++;
      if (sq.size() != 0 || tq.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d slips and %0d checks pending, want 0 and 0", sq.size(), tq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
